// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: shared tick prescaler plus per-channel OFF/ON/BLINK/BURST sequencer.
// Configuration arrives through a valid/ready port; each accepted write reloads one channel.
//
// state     | meaning
// S_OFF     | led dark, ignores ticks
// S_ON      | led lit, ignores ticks
// S_BL_ON   | blink, lit half-period
// S_BL_OFF  | blink, dark half-period
// S_BU_ON   | burst, lit half-period
// S_BU_OFF  | burst, dark half-period; decrements remain at its end
module led_blinker_multi #(
  parameter int CHANNELS = 4,
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1000,
  parameter int HALF_W   = 16,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [HALF_W-1:0]   cfg_half,
  input  logic [CNT_W-1:0]    cfg_count,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int P  = CLK_HZ / TICK_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_ON     = 3'd1;
  localparam logic [2:0] S_BL_ON  = 3'd2;
  localparam logic [2:0] S_BL_OFF = 3'd3;
  localparam logic [2:0] S_BU_ON  = 3'd4;
  localparam logic [2:0] S_BU_OFF = 3'd5;

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic              rdy_q;
  logic              accept;
  logic [HALF_W-1:0] half_eff;

  // Prescaler free-runs; configuration never disturbs it.
  assign tick = (pre_cnt == PW'(P - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign cfg_ready = rdy_q;
  assign accept    = cfg_valid && rdy_q;
  assign half_eff  = (cfg_half == '0) ? HALF_W'(1) : cfg_half;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [2:0]        state;
    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] phase;
    logic [CNT_W-1:0]  remain;
    logic              led_q;
    logic              busy_q;
    logic              done_q;
    logic              hit;
    logic              phase_end;

    assign hit       = accept && (cfg_ch == CH_W'(c));
    assign phase_end = (phase == half_q - HALF_W'(1));

    // A write to this channel takes priority over a coincident tick.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= S_OFF;
        half_q <= HALF_W'(1);
        phase  <= '0;
        remain <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (hit) begin
          half_q <= half_eff;
          phase  <= '0;
          remain <= cfg_count;
          case (cfg_mode)
            2'd0: begin
              state  <= S_OFF;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
            end
            2'd1: begin
              state  <= S_ON;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            2'd2: begin
              state  <= S_BL_ON;
              led_q  <= 1'b1;
              busy_q <= 1'b0;
            end
            default: begin
              if (cfg_count == '0) begin
                state  <= S_OFF;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state  <= S_BU_ON;
                led_q  <= 1'b1;
                busy_q <= 1'b1;
              end
            end
          endcase
        end else if (tick && (state >= S_BL_ON)) begin
          if (!phase_end) begin
            phase <= phase + HALF_W'(1);
          end else begin
            phase <= '0;
            case (state)
              S_BL_ON: begin
                state <= S_BL_OFF;
                led_q <= 1'b0;
              end
              S_BL_OFF: begin
                state <= S_BL_ON;
                led_q <= 1'b1;
              end
              S_BU_ON: begin
                state <= S_BU_OFF;
                led_q <= 1'b0;
              end
              S_BU_OFF: begin
                remain <= remain - CNT_W'(1);
                if (remain == CNT_W'(1)) begin
                  state  <= S_OFF;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  state <= S_BU_ON;
                  led_q <= 1'b1;
                end
              end
              default: begin
                state  <= S_OFF;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
              end
            endcase
          end
        end
      end
    end

    assign led[c]  = led_q;
    assign busy[c] = busy_q;
    assign done[c] = done_q;
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Bench for led_blinker_multi: vector table, directed timing sequences and random configs
// checked every cycle against a tick-counting reference model.
module tb_led_blinker_multi;
  localparam int NCH = 4;
  localparam int P   = 10;
  localparam int HW  = 16;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [HW-1:0] cfg_half = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [3:0]    led, busy, done;

  logic          cfg_valid5 = 1'b0;
  logic          cfg_ready5;
  logic [2:0]    cfg_ch5 = '0;
  logic [4:0]    led5, busy5, done5;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  led_blinker_multi #(.CHANNELS(4), .CLK_HZ(1000), .TICK_HZ(100), .HALF_W(HW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led), .busy(busy), .done(done));

  // Five channels give a 3-bit channel field so out-of-range targets can be exercised.
  led_blinker_multi #(.CHANNELS(5), .CLK_HZ(1000), .TICK_HZ(100), .HALF_W(HW), .CNT_W(CW)) u_dut5 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5), .cfg_ch(cfg_ch5),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led5), .busy(busy5), .done(done5));

  // Reference model: counts ticks since the last write and derives outputs arithmetically.
  int cyc;
  bit rdy_m;
  int m_mode[NCH];
  int m_half[NCH];
  int m_cnt[NCH];
  int m_k[NCH];
  bit m_done[NCH];

  always @(posedge clk) begin : mdl
    bit tk;
    tk = ((cyc % P) == P - 1);
    if (rst) begin
      cyc = 0;
      rdy_m = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_half[c] = 1; m_cnt[c] = 0; m_k[c] = 0; m_done[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_done[c] = 1'b0;
        if (cfg_valid && rdy_m && (cfg_ch == c)) begin
          m_mode[c] = cfg_mode;
          m_half[c] = (cfg_half == 0) ? 1 : int'(cfg_half);
          m_cnt[c]  = cfg_count;
          m_k[c]    = 0;
          if (m_mode[c] == 3 && m_cnt[c] == 0) begin
            m_mode[c] = 0; m_done[c] = 1'b1;
          end
        end else if (tk && m_mode[c] >= 2) begin
          m_k[c]++;
          if (m_mode[c] == 3 && m_k[c] == 2 * m_cnt[c] * m_half[c]) begin
            m_mode[c] = 0; m_done[c] = 1'b1;
          end
        end
      end
      rdy_m = 1'b1;
      cyc++;
    end
  end

  function automatic logic [3:0] exp_led();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++)
      case (m_mode[c])
        0:       v[c] = 1'b0;
        1:       v[c] = 1'b1;
        default: v[c] = ((m_k[c] / m_half[c]) % 2) == 0;
      endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (m_mode[c] == 3);
    return v;
  endfunction

  function automatic logic [3:0] exp_done();
    logic [3:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_done[c];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d t=%0t", name, act, lo, hi, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("mdl_led", led, exp_led());
      check("mdl_busy", busy, exp_busy());
      check("mdl_done", done, exp_done());
      check("mdl_ready", cfg_ready, rdy_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int mode, input int half, input int count);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
    cfg_half = HW'(half); cfg_count = CW'(count);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic cfg5(input int ch, input int mode, input int half, input int count);
    cfg_valid5 = 1'b1; cfg_ch5 = 3'(ch); cfg_mode = 2'(mode);
    cfg_half = HW'(half); cfg_count = CW'(count);
    step();
    cfg_valid5 = 1'b0;
  endtask

  task automatic wait_led(input int ch, input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (led[ch] !== lvl && n < budget);
  endtask

  typedef struct {
    int ch; int mode; int half; int count;
    logic [3:0] led; logic [3:0] busy; logic [3:0] done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n, nb;
    tbl[0] = '{1, 1, 0, 0, 4'b0010, 4'b0000, 4'b0000};
    tbl[1] = '{1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
    tbl[2] = '{3, 1, 0, 0, 4'b1000, 4'b0000, 4'b0000};
    tbl[3] = '{0, 2, 3, 0, 4'b1001, 4'b0000, 4'b0000};
    tbl[4] = '{2, 3, 1, 2, 4'b1101, 4'b0100, 4'b0000};
    tbl[5] = '{2, 3, 1, 0, 4'b1001, 4'b0000, 4'b0100};
    tbl[6] = '{2, 1, 0, 0, 4'b1101, 4'b0000, 4'b0000};
    tbl[7] = '{0, 0, 0, 0, 4'b1100, 4'b0000, 4'b0000};
    tbl[8] = '{3, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000};
    tbl[9] = '{2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000};

    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_led", led, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cfg_ready, 0);
    end
    rst = 1'b0;
    step();
    check("ready_after_rst", cfg_ready, 1);

    for (int i = 0; i < 10; i++) begin
      cfg(tbl[i].ch, tbl[i].mode, tbl[i].half, tbl[i].count);
      check($sformatf("tbl%0d_led", i), led, tbl[i].led);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d_done", i), done, tbl[i].done);
    end

    cfg(0, 2, 3, 0);
    check("blink3_start", led[0], 1);
    wait_led(0, 1'b0, 40, n);
    chk_range("blink3_first", n, 21, 30);
    for (int i = 0; i < 6; i++) begin
      wait_led(0, (i % 2 == 0), 40, n);
      check($sformatf("blink3_tog%0d", i), n, 30);
    end
    cfg(0, 2, 0, 0);
    check("blink0_start", led[0], 1);
    wait_led(0, 1'b0, 20, n);
    chk_range("blink0_first", n, 1, 10);
    for (int i = 0; i < 6; i++) begin
      wait_led(0, (i % 2 == 0), 20, n);
      check($sformatf("blink0_tog%0d", i), n, 10);
    end
    cfg(0, 0, 0, 0);

    cfg(2, 3, 1, 2);
    check("burst_led0", led[2], 1);
    check("burst_busy0", busy[2], 1);
    wait_led(2, 1'b0, 15, n);
    chk_range("burst_p1", n, 1, 10);
    wait_led(2, 1'b1, 15, n);
    check("burst_p2", n, 10);
    wait_led(2, 1'b0, 15, n);
    check("burst_p3", n, 10);
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (busy[2] !== 1'b1 || done[2] !== 1'b0 || led[2] !== 1'b0) nb++;
    end
    check("burst_p4_hold", nb, 0);
    step();
    check("burst_done", done[2], 1);
    check("burst_busy_fall", busy[2], 0);
    check("burst_led_end", led[2], 0);
    step();
    check("burst_done_1cyc", done[2], 0);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (led[2] !== 1'b0 || busy[2] !== 1'b0 || done[2] !== 1'b0) nb++;
    end
    check("burst_quiet", nb, 0);

    cfg(1, 3, 5, 0);
    check("cnt0_done", done[1], 1);
    check("cnt0_busy", busy[1], 0);
    step();
    check("cnt0_done_1cyc", done[1], 0);

    cfg(2, 3, 2, 3);
    for (int i = 0; i < 15; i++) step();
    cfg(2, 1, 0, 0);
    check("reconf_busy", busy[2], 0);
    check("reconf_led", led[2], 1);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done[2] !== 1'b0 || led[2] !== 1'b1) nb++;
    end
    check("reconf_no_done", nb, 0);

    cfg(2, 3, 1, 3);
    for (int i = 0; i < 12; i++) step();
    rst = 1'b1;
    step();
    check("midrst_led", led, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    step();
    check("midrst_ready", cfg_ready, 1);
    check("midrst_done2", done, 0);

    cfg(0, 2, 2, 0);
    cfg(3, 3, 1, 3);
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < P && (cyc % P) != P - 1; i++) step();
    check("tick_align", cyc % P, P - 1);
    cfg(3, 3, 1, 3);
    check("conc_led3", led[3], 1);
    wait_led(3, 1'b0, 15, n);
    check("conc_restart", n, 10);
    wait_led(0, !led[0], 25, n);
    chk_range("conc_ch0_sync", n, 1, 20);
    for (int i = 0; i < 2; i++) begin
      wait_led(0, !led[0], 25, n);
      check($sformatf("conc_ch0_tog%0d", i), n, 20);
    end

    cfg5(4, 1, 0, 0);
    check("ch5_base", led5, 5'b10000);
    for (int ch = 5; ch < 8; ch++) begin
      cfg5(ch, ch - 4, 1, 1);
      check($sformatf("badch%0d_led", ch), led5, 5'b10000);
      check($sformatf("badch%0d_busy", ch), busy5, 0);
    end
    for (int i = 0; i < 25; i++) step();
    check("badch_hold_led", led5, 5'b10000);
    check("badch_hold_done", done5, 0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(399) == 0);
      if (!rst && $urandom_range(15) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(3));
        cfg_mode  = 2'($urandom_range(3));
        cfg_half  = HW'($urandom_range(4));
        cfg_count = CW'($urandom_range(3));
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
